arcade_input: RTL and testbench

- Parametrised player-input and configuration front end for the arcade cores.
- Merges PS/2 keyboard events with N MiSTer joysticks into per-player direction, button, start and coin vectors.
- Adds per-button autofire, coin pulse stretching and a latched pause toggle.
- Captures the DIP-switch bank and game index from ioctl downloads.
- Sits between hps_io and the game module in the emu top level.

---
 rtl/arcade_input.sv | 199 +++++++++++++++++++
 tb/tb_arcade_input.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input.sv
// arcade_input: PS/2 + joystick merge, autofire, coin stretch, pause,
// and DIP / game-index capture from ioctl downloads.
module arcade_input #(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_BUTTONS  = 3,
  parameter int NUM_DIP      = 2,
  parameter int COIN_PULSE   = 960000,
  parameter int AUTOFIRE_DIV = 3200000,
  parameter int DIP_INDEX    = 254,
  parameter int GAME_INDEX   = 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [10:0]                          ps2_key,
  input  logic [NUM_PLAYERS*(NUM_BUTTONS+7)-1:0] joystick,
  input  logic [NUM_BUTTONS-1:0]               autofire_mask,
  input  logic [24:0]                          ioctl_addr,
  input  logic [7:0]                           ioctl_data,
  input  logic                                 ioctl_wr,
  input  logic [7:0]                           ioctl_index,
  output logic [NUM_PLAYERS*4-1:0]             joy,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0]   buttons,
  output logic [NUM_PLAYERS-1:0]               start,
  output logic [NUM_PLAYERS-1:0]               coin,
  output logic                                 pause,
  output logic [NUM_DIP*8-1:0]                 dip,
  output logic [3:0]                           game_index
);

  localparam int J  = NUM_BUTTONS + 7;
  localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

  typedef struct packed {
    logic       up;
    logic       down;
    logic       right;
    logic       left;
    logic [2:0] btn;
    logic       start;
    logic       coin;
  } keys_t;

  keys_t key_q [2];
  keys_t key_n [2];
  logic  pkey_q, pkey_n;
  logic  tog_q;
  logic  ev;
  logic  pr;
  logic [7:0] code;
  logic  unused_ext;

  logic [NUM_PLAYERS*4-1:0]           raw_joy;
  logic [NUM_PLAYERS*NUM_BUTTONS-1:0] raw_btn;
  logic [NUM_PLAYERS-1:0]             raw_start;
  logic [NUM_PLAYERS-1:0]             raw_coin;
  logic [NUM_PLAYERS-1:0]             raw_pause;
  logic                               pause_src;
  logic                               pause_prev;
  logic [NUM_PLAYERS-1:0]             coin_prev;
  logic [23:0]                        coin_cnt [NUM_PLAYERS];
  logic [AW-1:0]                      af_cnt;
  logic                               af_phase;
  logic [NUM_BUTTONS-1:0]             af_gate;

  assign ev         = ps2_key[10] != tog_q;
  assign pr         = ps2_key[9];
  assign code       = ps2_key[7:0];
  assign unused_ext = ps2_key[8];

  // Decode an accepted key event into the next key-register image.
  always_comb begin
    key_n  = key_q;
    pkey_n = pkey_q;
    if (ev) begin
      unique case (1'b1)
        (code == 8'h75): key_n[0].up     = pr;
        (code == 8'h72): key_n[0].down   = pr;
        (code == 8'h6B): key_n[0].left   = pr;
        (code == 8'h74): key_n[0].right  = pr;
        (code == 8'h14): key_n[0].btn[0] = pr;
        (code == 8'h11): key_n[0].btn[1] = pr;
        (code == 8'h29): key_n[0].btn[2] = pr;
        (code == 8'h16): key_n[0].start  = pr;
        (code == 8'h2E): key_n[0].coin   = pr;
        (code == 8'h2D): key_n[1].up     = pr;
        (code == 8'h2B): key_n[1].down   = pr;
        (code == 8'h23): key_n[1].left   = pr;
        (code == 8'h34): key_n[1].right  = pr;
        (code == 8'h1C): key_n[1].btn[0] = pr;
        (code == 8'h1B): key_n[1].btn[1] = pr;
        (code == 8'h15): key_n[1].btn[2] = pr;
        (code == 8'h1E): key_n[1].start  = pr;
        (code == 8'h36): key_n[1].coin   = pr;
        (code == 8'h4D): pkey_n          = pr;
        default: ;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
    localparam int B = p * J;
    logic [3:0]             kj;
    logic [NUM_BUTTONS-1:0] kb;
    logic                   ks;
    logic                   kc;
    if (p < 2) begin : g_key
      assign kj = {key_q[p].up, key_q[p].down,
                   key_q[p].right, key_q[p].left};
      assign ks = key_q[p].start;
      assign kc = key_q[p].coin;
      for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_kb
        if (b < 3) begin : g_on
          assign kb[b] = key_q[p].btn[b];
        end else begin : g_off
          assign kb[b] = 1'b0;
        end
      end
    end else begin : g_nokey
      assign kj = '0;
      assign kb = '0;
      assign ks = 1'b0;
      assign kc = 1'b0;
    end
    assign raw_joy[p*4 +: 4] = kj | {joystick[B+3], joystick[B+2],
                                     joystick[B+0], joystick[B+1]};
    assign raw_btn[p*NUM_BUTTONS +: NUM_BUTTONS] =
      kb | joystick[B+4 +: NUM_BUTTONS];
    assign raw_start[p] = ks | joystick[B+4+NUM_BUTTONS];
    assign raw_coin[p]  = kc | joystick[B+5+NUM_BUTTONS];
    assign raw_pause[p] = joystick[B+6+NUM_BUTTONS];
  end

  assign pause_src = pkey_q | (|raw_pause);
  assign af_gate   = {NUM_BUTTONS{af_phase}} | ~autofire_mask;

  // Key state, autofire clock, coin stretchers, pause and outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tog_q      <= ps2_key[10];
      key_q[0]   <= '0;
      key_q[1]   <= '0;
      pkey_q     <= 1'b0;
      joy        <= '0;
      buttons    <= '0;
      start      <= '0;
      coin       <= '0;
      coin_prev  <= '0;
      pause      <= 1'b0;
      pause_prev <= 1'b0;
      af_cnt     <= '0;
      af_phase   <= 1'b1;
      for (int p = 0; p < NUM_PLAYERS; p++) coin_cnt[p] <= '0;
    end else begin
      tog_q   <= ps2_key[10];
      key_q   <= key_n;
      pkey_q  <= pkey_n;
      joy     <= raw_joy;
      buttons <= raw_btn & {NUM_PLAYERS{af_gate}};
      start   <= raw_start;
      if (af_cnt == AW'(AUTOFIRE_DIV - 1)) begin
        af_cnt   <= '0;
        af_phase <= ~af_phase;
      end else begin
        af_cnt <= af_cnt + 1'b1;
      end
      coin_prev <= raw_coin;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (raw_coin[p] && !coin_prev[p] && !coin[p]) begin
          coin_cnt[p] <= 24'(COIN_PULSE - 1);
          coin[p]     <= 1'b1;
        end else begin
          if (coin_cnt[p] != '0) coin_cnt[p] <= coin_cnt[p] - 1'b1;
          coin[p] <= coin[p] && (coin_cnt[p] != '0 || raw_coin[p]);
        end
      end
      pause_prev <= pause_src;
      pause      <= pause ^ (pause_src & ~pause_prev);
    end
  end

  logic [NUM_DIP*8-1:0] dip_q = '0;
  logic [3:0]           gidx_q = '0;

  // Download capture; deliberately outside reset so settings survive it.
  always_ff @(posedge clk) begin
    if (ioctl_wr && ioctl_index == 8'(DIP_INDEX)) begin
      for (int k = 0; k < NUM_DIP; k++) begin
        if (ioctl_addr == 25'(k)) dip_q[k*8 +: 8] <= ioctl_data;
      end
    end
    if (ioctl_wr && ioctl_index == 8'(GAME_INDEX)) begin
      gidx_q <= ioctl_data[3:0];
    end
  end

  assign dip        = dip_q;
  assign game_index = gidx_q;

endmodule

// File: tb/tb_arcade_input.sv
// tb_arcade_input: directed vectors for arcade_input
// with hand-computed expectations.
module tb_arcade_input;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [19:0] joystick;
  logic [2:0]  autofire_mask;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [7:0]  joy;
  logic [5:0]  buttons;
  logic [1:0]  start;
  logic [1:0]  coin;
  logic        pause;
  logic [15:0] dip;
  logic [3:0]  game_index;

  int vectors = 0;
  int errors  = 0;

  arcade_input #(
    .NUM_PLAYERS(2), .NUM_BUTTONS(3), .NUM_DIP(2),
    .COIN_PULSE(20), .AUTOFIRE_DIV(4),
    .DIP_INDEX(254), .GAME_INDEX(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key),
    .joystick(joystick), .autofire_mask(autofire_mask),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .joy(joy), .buttons(buttons), .start(start), .coin(coin),
    .pause(pause), .dip(dip), .game_index(game_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic pressed, input logic [7:0] c);
    ps2_key = {~ps2_key[10], pressed, 1'b0, c};
  endtask

  task automatic coin_run(input string tag, input int n,
                          input int lo, input int hi,
                          input int lo2, input int hi2,
                          input int exp);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      joystick[8] = (i >= lo && i < hi) || (i >= lo2 && i < hi2);
      tick();
      if (coin[0]) cnt++;
    end
    check(tag, cnt, exp);
  endtask

  initial begin
    int first, cnt;
    logic found, last;
    reset_n = 1'b0;
    ps2_key = '0;
    joystick = '0;
    autofire_mask = '0;
    ioctl_addr = '0;
    ioctl_data = '0;
    ioctl_wr = 1'b0;
    ioctl_index = '0;
    repeat (3) tick();
    check("rst_joy", joy, 0);
    check("rst_btn", buttons, 0);
    check("rst_start", start, 0);
    check("rst_coin", coin, 0);
    check("rst_pause", pause, 0);
    check("pwr_dip", dip, 0);
    check("pwr_gidx", game_index, 0);
    reset_n = 1'b1;
    tick();

    key(1'b1, 8'h75);
    first = -1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) key(1'b0, 8'h75);
      tick();
      if (joy[3]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    check("key_up_lat", first, 1);
    check("key_up_len", cnt, 10);

    key(1'b1, 8'h23);
    tick();
    tick();
    check("key_p1_left", joy, 8'h10);
    key(1'b0, 8'h23);
    tick();
    tick();
    check("key_p1_rel", joy, 8'h00);

    key(1'b1, 8'h5A);
    tick();
    tick();
    check("key_unlisted", {joy, buttons}, 0);
    ps2_key = {~ps2_key[10], 1'b1, 1'b1, 8'h14};
    tick();
    tick();
    check("key_ext_btn", buttons, 6'b000001);
    key(1'b1, 8'h1E);
    tick();
    tick();
    check("key_p1_start", start, 2'b10);
    key(1'b0, 8'h14);
    tick();
    key(1'b0, 8'h1E);
    tick();
    tick();
    check("key_rel_all", {buttons, start}, 0);

    joystick[3] = 1'b1;
    tick();
    check("joy_up", joy, 8'h08);
    joystick = 20'h00001;
    tick();
    check("joy_right", joy, 8'h02);
    joystick = 20'h00800;
    tick();
    check("joy_p1_left", joy, 8'h10);
    joystick = 20'h00080;
    tick();
    check("joy_start", start, 2'b01);
    joystick = 20'h00004;
    key(1'b1, 8'h6B);
    tick();
    check("simul_e1", joy, 8'h04);
    tick();
    check("simul_e2", joy, 8'h05);
    joystick = '0;
    key(1'b0, 8'h6B);
    tick();
    tick();
    check("simul_rel", joy, 8'h00);

    coin_run("coin_short", 40, 0, 3, 0, 0, 20);
    coin_run("coin_held", 80, 0, 50, 0, 0, 50);
    coin_run("coin_noretrig", 40, 0, 3, 5, 8, 20);

    autofire_mask = 3'b001;
    joystick = 20'h00030;
    found = 1'b0;
    last = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (buttons[0] && !last) found = 1'b1;
      last = buttons[0];
    end
    check("af_sync", found, 1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("af_b0", buttons[0], ((k >> 2) & 1) == 0);
      check("af_b1", buttons[5:1], 5'b00001);
    end
    joystick = '0;
    autofire_mask = '0;
    tick();

    key(1'b1, 8'h4D);
    tick();
    tick();
    check("pause_on", pause, 1);
    repeat (100) tick();
    check("pause_hold", pause, 1);
    key(1'b0, 8'h4D);
    tick();
    tick();
    check("pause_rel", pause, 1);
    key(1'b1, 8'h4D);
    tick();
    tick();
    check("pause_off", pause, 0);
    key(1'b0, 8'h4D);
    tick();
    tick();
    check("pause_rel2", pause, 0);
    joystick[19] = 1'b1;
    tick();
    check("pause_joy", pause, 1);
    repeat (3) tick();
    check("pause_joy_hold", pause, 1);
    joystick = '0;
    tick();

    ioctl_index = 8'd254;
    ioctl_wr = 1'b1;
    ioctl_addr = 25'd0; ioctl_data = 8'hA5; tick();
    ioctl_addr = 25'd1; ioctl_data = 8'h3C; tick();
    ioctl_addr = 25'd2; ioctl_data = 8'hFF; tick();
    ioctl_wr = 1'b0;
    tick();
    check("dip_write", dip, 16'h3CA5);

    ioctl_index = 8'd1; ioctl_data = 8'h07; ioctl_wr = 1'b1;
    tick();
    ioctl_index = 8'd0; ioctl_data = 8'h02;
    tick();
    ioctl_wr = 1'b0;
    tick();
    check("gidx_write", game_index, 7);

    reset_n = 1'b0;
    tick();
    ioctl_index = 8'd254; ioctl_addr = 25'd1;
    ioctl_data = 8'h5A; ioctl_wr = 1'b1;
    tick();
    ioctl_index = 8'd1; ioctl_data = 8'hF3;
    tick();
    ioctl_wr = 1'b0;
    tick();
    check("rst_dip_keep", dip, 16'h5AA5);
    check("rst_gidx", game_index, 3);
    check("rst2_pause", pause, 0);
    check("rst2_joycoin", {joy, coin}, 0);
    reset_n = 1'b1;
    tick();

    joystick[8] = 1'b1;
    repeat (3) tick();
    check("coin_mid", coin, 2'b01);
    reset_n = 1'b0;
    tick();
    check("coin_rst", coin, 0);
    joystick = '0;
    tick();
    reset_n = 1'b1;
    tick();
    check("coin_after_rst", coin, 0);
    check("dip_final", dip, 16'h5AA5);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end
endmodule
